seq_consumer: RTL and testbench

- Downstream consumer stage that drains the producer/FIFO pipeline.
- Pops the upstream FIFO one word at a time with a single-cycle request, captures the returned word and checks it against the expected incrementing sequence.
- Reports per-item valid pulses, an item count, a saturating error count, a sticky error flag, and a done flag after a fixed number of items.
- Replaces the free-running toggle consumer; pacing comes from an FSM with a programmable gap.

---
 rtl/seq_consumer.sv | 172 +++++++++++++++++
 tb/tb_seq_consumer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_consumer.sv
// Downstream consumer stage: pops the upstream FIFO one word at a time, checks
// each captured word against an incrementing expected sequence, and reports
// per-item valid pulses, an item count, a saturating error count, a sticky
// error flag and a done flag once NUM_ITEMS words have been consumed.
module seq_consumer #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned NUM_ITEMS = 10,
  parameter int unsigned GAP       = 1,
  parameter int unsigned START_VAL = 1
) (
  input  logic              seq_consumer_iclk,
  input  logic              seq_consumer_irst,
  input  logic              seq_consumer_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              consumer_req,
  output logic [DATA_W-1:0] consumer_data,
  output logic              consumer_valid,
  output logic [7:0]        item_count,
  output logic [7:0]        err_count,
  output logic              err_flag,
  output logic              done
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StCapture,
    StGap,
    StDone
  } state_e;

  // The gap counter holds GAP-1 down to 0, so GAP cycles are spent in StGap.
  localparam int unsigned GapW      = (GAP < 2) ? 1 : $clog2(GAP);
  localparam bit          HasGap    = (GAP > 0);
  localparam logic [GapW-1:0]   GapLoad   = HasGap ? GapW'(GAP - 1) : '0;
  localparam logic [7:0]        NumItems  = 8'(NUM_ITEMS);
  localparam logic [DATA_W-1:0] StartVal  = DATA_W'(START_VAL);
  localparam logic [7:0]        ErrMax    = 8'hFF;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [7:0]        item_q, item_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              err_flag_q, err_flag_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [GapW-1:0]   gap_q, gap_d;

  logic              match;
  logic [7:0]        item_inc;

  // Next-state logic: pacing FSM plus capture/sequence-check bookkeeping.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    item_d     = item_q;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    done_d     = done_q;
    exp_d      = exp_q;
    gap_d      = gap_q;
    match      = (fifo_data == exp_q);
    item_inc   = item_q + 8'd1;

    unique case (state_q)
      StIdle: begin
        if (seq_consumer_en && !fifo_empty) begin
          state_d = StReq;
        end
      end

      // Pop strobe is issued for exactly this cycle; data arrives next cycle.
      StReq: begin
        state_d = StCapture;
      end

      StCapture: begin
        data_d  = fifo_data;
        valid_d = 1'b1;
        item_d  = item_inc;
        // Match or not, the next expected word follows the one just seen, so a
        // dropped or repeated word costs exactly one error.
        exp_d   = fifo_data + DATA_W'(1);
        if (!match) begin
          err_flag_d = 1'b1;
          if (err_cnt_q != ErrMax) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
        if (item_inc == NumItems) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (HasGap) begin
          state_d = StGap;
          gap_d   = GapLoad;
        end else begin
          state_d = StIdle;
        end
      end

      StGap: begin
        if (gap_q == '0) begin
          if (item_q == NumItems) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end

      StDone: begin
        done_d = 1'b1;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; synchronous reset abandons any in-flight pop.
  always_ff @(posedge seq_consumer_iclk) begin
    if (seq_consumer_irst) begin
      state_q    <= StIdle;
      data_q     <= '0;
      valid_q    <= 1'b0;
      item_q     <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
      done_q     <= 1'b0;
      exp_q      <= StartVal;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      item_q     <= item_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
      done_q     <= done_d;
      exp_q      <= exp_d;
      gap_q      <= gap_d;
    end
  end

  // Output decode: the pop strobe is a Moore output of StReq.
  always_comb begin
    consumer_req   = (state_q == StReq);
    consumer_data  = data_q;
    consumer_valid = valid_q;
    item_count     = item_q;
    err_count      = err_cnt_q;
    err_flag       = err_flag_q;
    done           = done_q;
  end

  // A valid pulse always lands in the cycle after StCapture, never in StReq.
  a_req_valid_excl: assert property (
    @(posedge seq_consumer_iclk) disable iff (seq_consumer_irst)
      !(consumer_req && consumer_valid));

  a_item_bound: assert property (
    @(posedge seq_consumer_iclk) disable iff (seq_consumer_irst)
      item_count <= NumItems);

endmodule

// File: tb/tb_seq_consumer.sv
// Bench for seq_consumer: three instances (defaults, wrap-around start value,
// GAP=0 with saturation), a FIFO model that answers each pop, a reference
// model that predicts each capture and a scoreboard monitor on valid pulses.
module tb_seq_consumer;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   [NI];
  logic       en    [NI];
  logic       empty [NI];
  logic [3:0] fdata [NI];
  wire        req   [NI];
  wire  [3:0] cdata [NI];
  wire        valid [NI];
  wire  [7:0] icnt  [NI];
  wire  [7:0] ecnt  [NI];
  wire        eflag [NI];
  wire        done  [NI];

  int num_tbl   [NI] = '{10, 4, 255};
  int start_tbl [NI] = '{1, 14, 1};
  int space_tbl [NI] = '{4, 4, 3};

  seq_consumer #(.DATA_W(4), .NUM_ITEMS(10), .GAP(1), .START_VAL(1)) u_a (
    .seq_consumer_iclk(clk), .seq_consumer_irst(rst[0]), .seq_consumer_en(en[0]),
    .fifo_empty(empty[0]), .fifo_data(fdata[0]), .consumer_req(req[0]),
    .consumer_data(cdata[0]), .consumer_valid(valid[0]), .item_count(icnt[0]),
    .err_count(ecnt[0]), .err_flag(eflag[0]), .done(done[0])
  );

  seq_consumer #(.DATA_W(4), .NUM_ITEMS(4), .GAP(1), .START_VAL(14)) u_w (
    .seq_consumer_iclk(clk), .seq_consumer_irst(rst[1]), .seq_consumer_en(en[1]),
    .fifo_empty(empty[1]), .fifo_data(fdata[1]), .consumer_req(req[1]),
    .consumer_data(cdata[1]), .consumer_valid(valid[1]), .item_count(icnt[1]),
    .err_count(ecnt[1]), .err_flag(eflag[1]), .done(done[1])
  );

  seq_consumer #(.DATA_W(4), .NUM_ITEMS(255), .GAP(0), .START_VAL(1)) u_s (
    .seq_consumer_iclk(clk), .seq_consumer_irst(rst[2]), .seq_consumer_en(en[2]),
    .fifo_empty(empty[2]), .fifo_data(fdata[2]), .consumer_req(req[2]),
    .consumer_data(cdata[2]), .consumer_valid(valid[2]), .item_count(icnt[2]),
    .err_count(ecnt[2]), .err_flag(eflag[2]), .done(done[2])
  );

  typedef struct {
    int         inst;
    logic [3:0] data;
    int         items;
    int         errs;
    int         flag;
  } exp_t;

  exp_t       sb [$];
  logic [3:0] feed_a [$];
  logic [3:0] wctr;

  int m_exp   [NI];
  int m_items [NI];
  int m_errs  [NI];
  int m_flag  [NI];
  int last_req [NI];
  int req_cnt  [NI];
  bit req_seen [NI];
  bit chk_space [NI];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  task automatic check(input string name, input int act, input int want);
    vectors++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, wanted %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic void m_reset(input int i);
    m_exp[i]    = start_tbl[i];
    m_items[i]  = 0;
    m_errs[i]   = 0;
    m_flag[i]   = 0;
    last_req[i] = -1;
    req_cnt[i]  = 0;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].inst == i) sb.delete(k);
    end
    if (i == 1) wctr = 4'd14;
  endfunction

  // FIFO model: answers a pop seen in the previous cycle and predicts the capture.
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int i = 0; i < NI; i++) begin
      if (req_seen[i]) begin
        logic [3:0] w;
        exp_t       e;
        req_seen[i] = 1'b0;
        if (i == 0) begin
          if (feed_a.size() != 0) w = feed_a.pop_front();
          else w = 4'($urandom_range(0, 15));
        end else if (i == 1) begin
          w    = wctr;
          wctr = wctr + 4'd1;
        end else begin
          w = 4'd0;
        end
        fdata[i] = w;
        m_items[i]++;
        if (int'(w) != m_exp[i]) begin
          if (m_errs[i] < 255) m_errs[i]++;
          m_flag[i] = 1;
        end
        m_exp[i] = (int'(w) + 1) % 16;
        e.inst  = i;
        e.data  = w;
        e.items = m_items[i];
        e.errs  = m_errs[i];
        e.flag  = m_flag[i];
        sb.push_back(e);
      end
    end
  end

  // Monitor: pop spacing, and scoreboard comparison on every valid pulse.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      req_seen[i] = req[i];
      if (req[i]) begin
        req_cnt[i]++;
        if (chk_space[i] && last_req[i] >= 0)
          check($sformatf("u%0d req spacing", i), cyc - last_req[i], space_tbl[i]);
        last_req[i] = cyc;
      end
      if (done[i]) check($sformatf("u%0d req while done", i), int'(req[i]), 0);
      if (valid[i]) begin
        int found;
        found = -1;
        for (int k = 0; k < sb.size(); k++) begin
          if (sb[k].inst == i) begin
            found = k;
            break;
          end
        end
        if (found < 0) begin
          check($sformatf("u%0d unexpected valid", i), 1, 0);
        end else begin
          exp_t e;
          e = sb[found];
          sb.delete(found);
          check($sformatf("u%0d data", i), int'(cdata[i]), int'(e.data));
          check($sformatf("u%0d item_count", i), int'(icnt[i]), e.items);
          check($sformatf("u%0d err_count", i), int'(ecnt[i]), e.errs);
          check($sformatf("u%0d err_flag", i), int'(eflag[i]), e.flag);
          check($sformatf("u%0d done", i), int'(done[i]), (e.items == num_tbl[i]) ? 1 : 0);
          check($sformatf("u%0d req with valid", i), int'(req[i]), 0);
        end
      end
    end
  end

  task automatic reset_a();
    @(negedge clk);
    rst[0] = 1'b1;
    repeat (2) @(negedge clk);
    m_reset(0);
    feed_a.delete();
    chk_space[0] = 1'b0;
    rst[0] = 1'b0;
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (req[0]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_items(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (int'(icnt[0]) >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running, wanted finished");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n;
    logic [3:0] w;

    wctr = 4'd14;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1;
      en[i] = 1'b0;
      empty[i] = 1'b1;
      fdata[i] = 4'd0;
      req_seen[i] = 1'b0;
      chk_space[i] = 1'b0;
      m_reset(i);
    end
    repeat (3) @(negedge clk);

    // Reset state.
    check("reset req", int'(req[0]), 0);
    check("reset valid", int'(valid[0]), 0);
    check("reset data", int'(cdata[0]), 0);
    check("reset item_count", int'(icnt[0]), 0);
    check("reset err_count", int'(ecnt[0]), 0);
    check("reset err_flag", int'(eflag[0]), 0);
    check("reset done", int'(done[0]), 0);

    // Free-running instances start here.
    for (int i = 1; i < NI; i++) begin
      en[i] = 1'b1;
      empty[i] = 1'b0;
      chk_space[i] = 1'b1;
      rst[i] = 1'b0;
    end

    // Nominal: 1..10, never empty.
    m_reset(0);
    for (int v = 1; v <= 10; v++) feed_a.push_back(4'(v));
    chk_space[0] = 1'b1;
    en[0] = 1'b1;
    empty[0] = 1'b0;
    rst[0] = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done[0]) begin
        ok = 1'b1;
        break;
      end
    end
    check("nominal done reached", int'(ok), 1);
    @(negedge clk);
    check("nominal done held", int'(done[0]), 1);
    repeat (20) @(negedge clk);
    check("nominal req pulses", req_cnt[0], 10);
    check("nominal err_count", int'(ecnt[0]), 0);
    check("nominal err_flag", int'(eflag[0]), 0);
    check("nominal item_count", int'(icnt[0]), 10);

    // Dropped word: 1,2,4,5.
    reset_a();
    feed_a = '{4'd1, 4'd2, 4'd4, 4'd5};
    en[0] = 1'b1;
    empty[0] = 1'b0;
    wait_items(3, 40, ok);
    check("drop reached third", int'(ok), 1);
    check("drop err after 4", int'(ecnt[0]), 1);
    check("drop flag after 4", int'(eflag[0]), 1);
    wait_items(4, 40, ok);
    empty[0] = 1'b1;
    check("drop reached fourth", int'(ok), 1);
    repeat (6) @(negedge clk);
    check("drop item_count", int'(icnt[0]), 4);
    check("drop err_count", int'(ecnt[0]), 1);

    // Empty/enable stall.
    reset_a();
    feed_a = '{4'd1, 4'd2, 4'd3};
    en[0] = 1'b1;
    empty[0] = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (req[0]) n++;
    end
    check("stall req while empty", n, 0);
    empty[0] = 1'b0;
    @(negedge clk);
    check("req after empty drop", int'(req[0]), 1);
    en[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("en drop capture valid", int'(valid[0]), 1);
    check("en drop item_count", int'(icnt[0]), 1);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (req[0]) n++;
    end
    check("stall req while en low", n, 0);
    en[0] = 1'b1;
    wait_req(10, ok);
    check("req after en high", int'(ok), 1);

    // Reset during CAPTURE, after one mismatching capture.
    reset_a();
    feed_a = '{4'd3, 4'd4, 4'd5};
    en[0] = 1'b1;
    empty[0] = 1'b0;
    wait_items(1, 20, ok);
    check("pre-reset capture", int'(ok), 1);
    wait_req(10, ok);
    check("pre-reset second req", int'(ok), 1);
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    check("midrst valid", int'(valid[0]), 0);
    check("midrst req", int'(req[0]), 0);
    check("midrst data", int'(cdata[0]), 0);
    check("midrst item_count", int'(icnt[0]), 0);
    check("midrst err_count", int'(ecnt[0]), 0);
    check("midrst err_flag", int'(eflag[0]), 0);
    check("midrst done", int'(done[0]), 0);
    m_reset(0);
    feed_a = '{4'd1, 4'd2, 4'd3};
    rst[0] = 1'b0;
    wait_items(1, 20, ok);
    check("post-reset capture", int'(ok), 1);
    check("post-reset match", int'(ecnt[0]), 0);

    // Randomized episodes with drops, repeats, glitches and stalls.
    for (int ep = 0; ep < 8; ep++) begin
      reset_a();
      w = 4'd1;
      for (int k = 0; k < 14; k++) begin
        int r;
        feed_a.push_back(w);
        r = $urandom_range(0, 9);
        if (r == 0) w = w + 4'd2;
        else if (r == 1) w = w;
        else if (r == 2) w = 4'($urandom_range(0, 15));
        else w = w + 4'd1;
      end
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (done[0]) begin
          ok = 1'b1;
          break;
        end
        en[0] = ($urandom_range(0, 4) != 0);
        empty[0] = ($urandom_range(0, 3) == 0);
      end
      check($sformatf("random ep%0d done", ep), int'(ok), 1);
      check($sformatf("random ep%0d item_count", ep), int'(icnt[0]), 10);
    end

    // Wrap and saturation instances.
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done[2]) begin
        ok = 1'b1;
        break;
      end
    end
    check("sat done reached", int'(ok), 1);
    check("sat err_count", int'(ecnt[2]), 255);
    check("sat item_count", int'(icnt[2]), 255);
    check("sat err_flag", int'(eflag[2]), 1);
    check("wrap done", int'(done[1]), 1);
    check("wrap err_count", int'(ecnt[1]), 0);
    check("wrap last data", int'(cdata[1]), 1);
    repeat (4) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
